// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Multicycle control sequencer for the RISC datapath. Walks each instruction
// through FETCH, DECODE, EXEC, optional MEM and WB, driving the write enables
// of the falling-edge datapath registers, the memory strobes and mux selects.
// State and wait counter are falling-edge flops; outputs are Mealy
// (state, OPCODE, ZERO, MEM_READY).
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> illegal opcode in DECODE enters TRAP (sticky until R)
//   undefined -> illegal opcode is a NOP, DECODE returns to FETCH
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] OPCODE,
  input  logic       ZERO,
  input  logic       MEM_READY,
  input  logic       STALL,
  output logic       PC_WE,
  output logic [1:0] PC_SRC,
  output logic       IR_WE,
  output logic       RF_WE,
  output logic       WB_SEL,
  output logic       ALU_SRC,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic [2:0] STATE,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_LOAD  = 3'd1,
    CL_STORE = 3'd2,
    CL_BEQ   = 3'd3,
    CL_JMP   = 3'd4,
    CL_HALT  = 3'd5,
    CL_ILL   = 3'd6
  } op_class_t;

  localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Map the 4-bit opcode onto its instruction class.
  function automatic op_class_t decode_class(input logic [3:0] op);
    op_class_t cls;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: cls = CL_ALU;
      4'b0100: cls = CL_LOAD;
      4'b0101: cls = CL_STORE;
      4'b0110: cls = CL_BEQ;
      4'b0111: cls = CL_JMP;
      4'b1111: cls = CL_HALT;
      default: cls = CL_ILL;
    endcase
    return cls;
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  op_class_t        op_cls_s;
  logic             mem_wait_st_s;
  logic             timeout_s;

  logic       pc_we_s;
  logic [1:0] pc_src_s;
  logic       ir_we_s;
  logic       rf_we_s;
  logic       wb_sel_s;
  logic       alu_src_s;
  logic       mem_rd_s;
  logic       mem_wr_s;
  logic       halted_s;

  assign op_cls_s      = decode_class(OPCODE);
  assign mem_wait_st_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign timeout_s     = (cnt_r == WAIT_MAX_C);

  // State and wait counter update on the falling edge, same as the datapath flops.
  always_ff @(negedge CLK or posedge R) begin
    if (R) begin
      state_r <= ST_FETCH;
      cnt_r   <= CNT_ZERO_C;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state selection; STALL freezes the sequencer in place.
  always_comb begin
    state_nx_s = state_r;
    if (STALL) begin
      state_nx_s = state_r;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // A completing access on the timeout edge still wins over ERR.
          if (MEM_READY) begin
            state_nx_s = ST_DECODE;
          end else if (timeout_s) begin
            state_nx_s = ST_ERR;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          case (op_cls_s)
            CL_ALU, CL_LOAD, CL_STORE, CL_BEQ, CL_JMP: state_nx_s = ST_EXEC;
            CL_HALT: state_nx_s = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
            default: state_nx_s = ST_TRAP;
`else
            default: state_nx_s = ST_FETCH;
`endif
          endcase
        end
        ST_EXEC: begin
          case (op_cls_s)
            CL_LOAD, CL_STORE: state_nx_s = ST_MEM;
            CL_ALU:            state_nx_s = ST_WB;
            default:           state_nx_s = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (MEM_READY) begin
            if (op_cls_s == CL_LOAD) begin
              state_nx_s = ST_WB;
            end else begin
              state_nx_s = ST_FETCH;
            end
          end else if (timeout_s) begin
            state_nx_s = ST_ERR;
          end else begin
            state_nx_s = ST_MEM;
          end
        end
        ST_WB:                     state_nx_s = ST_FETCH;
        ST_HALT, ST_TRAP, ST_ERR:  state_nx_s = state_r;
        default:                   state_nx_s = ST_ERR;
      endcase
    end
  end

  // Wait counter: clears on any state change, counts stalled-free waits on memory.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (state_nx_s != state_r) begin
      cnt_nx_s = CNT_ZERO_C;
    end else if (!STALL && mem_wait_st_s && !MEM_READY) begin
      cnt_nx_s = cnt_r + CNT_ONE_C;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Raw control decode from state and the held instruction fields.
  always_comb begin
    pc_we_s   = 1'b0;
    pc_src_s  = 2'b00;
    ir_we_s   = 1'b0;
    rf_we_s   = 1'b0;
    wb_sel_s  = 1'b0;
    alu_src_s = 1'b0;
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    halted_s  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_rd_s = 1'b1;
        if (MEM_READY) begin
          ir_we_s  = 1'b1;
          pc_we_s  = 1'b1;
          pc_src_s = 2'b00;
        end else begin
          ir_we_s  = 1'b0;
          pc_we_s  = 1'b0;
        end
      end
      ST_DECODE: begin
        pc_we_s = 1'b0;
      end
      ST_EXEC: begin
        if (op_cls_s == CL_LOAD || op_cls_s == CL_STORE) begin
          alu_src_s = 1'b1;
        end else begin
          alu_src_s = 1'b0;
        end
        case (op_cls_s)
          CL_BEQ: begin
            pc_we_s  = ZERO;
            pc_src_s = 2'b01;
          end
          CL_JMP: begin
            pc_we_s  = 1'b1;
            pc_src_s = 2'b10;
          end
          default: begin
            pc_we_s  = 1'b0;
            pc_src_s = 2'b00;
          end
        endcase
      end
      ST_MEM: begin
        case (op_cls_s)
          CL_LOAD:  mem_rd_s = 1'b1;
          CL_STORE: mem_wr_s = 1'b1;
          default:  mem_rd_s = 1'b0;
        endcase
      end
      ST_WB: begin
        rf_we_s  = 1'b1;
        wb_sel_s = (op_cls_s == CL_LOAD);
      end
      ST_HALT, ST_TRAP, ST_ERR: begin
        halted_s = 1'b1;
      end
      default: begin
        halted_s = 1'b1;
      end
    endcase
  end

  // Output gating: R clears everything, STALL blocks register writes and stores.
  always_comb begin
    PC_WE   = 1'b0;
    PC_SRC  = 2'b00;
    IR_WE   = 1'b0;
    RF_WE   = 1'b0;
    WB_SEL  = 1'b0;
    ALU_SRC = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    STATE   = 3'd0;
    HALTED  = 1'b0;
    if (R) begin
      STATE = 3'd0;
    end else begin
      PC_SRC  = pc_src_s;
      WB_SEL  = wb_sel_s;
      ALU_SRC = alu_src_s;
      MEM_RD  = mem_rd_s;
      STATE   = state_r;
      HALTED  = halted_s;
      if (STALL) begin
        PC_WE  = 1'b0;
        IR_WE  = 1'b0;
        RF_WE  = 1'b0;
        MEM_WR = 1'b0;
      end else begin
        PC_WE  = pc_we_s;
        IR_WE  = ir_we_s;
        RF_WE  = rf_we_s;
        MEM_WR = mem_wr_s;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed scenarios followed by random
// stimulus. Each driven cycle pushes the reference model's expected outputs
// into a queue; a monitor pops and compares once per cycle.
module tb_multicycle_ctrl_fsm;

  localparam int WMAX = 15;

  logic       CLK = 1'b0;
  logic       R = 1'b1;
  logic [3:0] OPCODE = 4'h0;
  logic       ZERO = 1'b0;
  logic       MEM_READY = 1'b0;
  logic       STALL = 1'b0;
  logic       PC_WE;
  logic [1:0] PC_SRC;
  logic       IR_WE;
  logic       RF_WE;
  logic       WB_SEL;
  logic       ALU_SRC;
  logic       MEM_RD;
  logic       MEM_WR;
  logic [2:0] STATE;
  logic       HALTED;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(WMAX), .CNT_W(8)) dut (
    .CLK(CLK), .R(R), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .STALL(STALL), .PC_WE(PC_WE), .PC_SRC(PC_SRC), .IR_WE(IR_WE),
    .RF_WE(RF_WE), .WB_SEL(WB_SEL), .ALU_SRC(ALU_SRC), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .STATE(STATE), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  logic [13:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: position along the instruction's step list, wait count,
  // and sticky stop state (0 = running, else 5/6/7).
  int m_pos = 0;
  int m_wait = 0;
  int m_halt = 0;

  // 0 ALU, 1 LOAD, 2 STORE, 3 BEQ, 4 JMP, 5 HALT, 6 illegal
  function automatic int op_class(input logic [3:0] op);
    if (op <= 4'd3) return 0;
    if (op == 4'd4) return 1;
    if (op == 4'd5) return 2;
    if (op == 4'd6) return 3;
    if (op == 4'd7) return 4;
    if (op == 4'd15) return 5;
    return 6;
  endfunction

  // Step list of each class: FETCH, DECODE, then class-specific steps; -1 = done.
  function automatic int path_state(input int cls, input int pos);
    if (pos == 0) return 0;
    if (pos == 1) return 1;
    case (cls)
      0: return (pos == 2) ? 2 : (pos == 3) ? 4 : -1;
      1: return (pos <= 4) ? pos : -1;
      2: return (pos <= 3) ? pos : -1;
      3, 4: return (pos == 2) ? 2 : -1;
      5: return (pos == 2) ? 5 : -1;
`ifdef ILLEGAL_TRAP_EN
      default: return (pos == 2) ? 6 : -1;
`else
      default: return -1;
`endif
    endcase
  endfunction

  // Drive one cycle, record the expected outputs, advance the model.
  task automatic step(input logic r, input logic [3:0] op, input logic z,
                      input logic rdy, input logic st);
    int cls;
    int cur;
    int ns;
    logic pcwe, irwe, rfwe, wbsel, alusrc, mrd, mwr, hlt;
    logic [1:0] pcsrc;
    @(posedge CLK);
    #1;
    R = r; OPCODE = op; ZERO = z; MEM_READY = rdy; STALL = st;
    cls = op_class(op);
    cur = (m_halt != 0) ? m_halt : path_state(cls, m_pos);
    pcwe = 1'b0; irwe = 1'b0; rfwe = 1'b0; wbsel = 1'b0; alusrc = 1'b0;
    mrd = 1'b0; mwr = 1'b0; hlt = 1'b0; pcsrc = 2'b00;
    if (r) cur = 0;
    else begin
      if (cur == 0) begin
        mrd = 1'b1; irwe = rdy & ~st; pcwe = rdy & ~st;
      end
      if (cur == 2) begin
        alusrc = (cls == 1 || cls == 2);
        if (cls == 3) begin pcsrc = 2'b01; pcwe = z & ~st; end
        if (cls == 4) begin pcsrc = 2'b10; pcwe = ~st; end
      end
      if (cur == 3) begin
        mrd = (cls == 1); mwr = (cls == 2) & ~st;
      end
      if (cur == 4) begin
        rfwe = ~st; wbsel = (cls == 1);
      end
      if (cur >= 5) hlt = 1'b1;
    end
    exp_q.push_back({pcwe, pcsrc, irwe, rfwe, wbsel, alusrc, mrd, mwr, 3'(cur), hlt});
    if (r) begin
      m_pos = 0; m_wait = 0; m_halt = 0;
    end else if (m_halt == 0 && !st) begin
      if ((cur == 0 || cur == 3) && !rdy) begin
        if (m_wait == WMAX) begin m_halt = 7; m_wait = 0; end
        else m_wait++;
      end else begin
        m_wait = 0;
        m_pos++;
        ns = path_state(cls, m_pos);
        if (ns < 0) m_pos = 0;
        else if (ns >= 5) m_halt = ns;
      end
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  always @(posedge CLK) begin
    logic [13:0] e;
    logic [13:0] act;
    #3;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {PC_WE, PC_SRC, IR_WE, RF_WE, WB_SEL, ALU_SRC, MEM_RD, MEM_WR, STATE, HALTED};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle%0d outputs {pcwe,pcsrc,irwe,rfwe,wbsel,alusrc,rd,wr,state,halted}: got %b required %b",
                 cyc, act, e);
      end
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int halt_cnt;
    int k;
    logic [3:0] op;
    logic rdy, st, rr;

    do_reset(2);
    // ALU with memory always ready: 0,1,2,4
    for (int i = 0; i < 4; i++) step(1'b0, 4'h2, 1'b0, 1'b1, 1'b0);
    // LOAD with 3 not-ready cycles in MEM
    for (int i = 0; i < 3; i++) step(1'b0, 4'h4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 4'h4, 1'b0, 1'b1, 1'b0);
    // STORE
    for (int i = 0; i < 4; i++) step(1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    // BEQ taken, BEQ not taken, JMP
    for (int i = 0; i < 3; i++) step(1'b0, 4'h6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
    // Reset in the middle of a STORE memory access
    for (int i = 0; i < 3; i++) step(1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h2, 1'b0, 1'b1, 1'b0);
    // Fetch timeout -> ERR, then the same with ready on the final edge
    for (int i = 0; i < WMAX + 1; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < WMAX; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    // Illegal opcode, then HALT
    for (int i = 0; i < 4; i++) step(1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    // STALL during EXEC of JMP, then during FETCH and MEM
    for (int i = 0; i < 2; i++) step(1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h7, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 4'h5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 4'h5, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'h5, 1'b0, 1'b1, 1'b0);

    // Random traffic; periodic starvation windows provoke timeouts
    halt_cnt = 0;
    op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (m_pos == 0 && m_halt == 0) begin
        k = $urandom_range(0, 19);
        if (k < 16) op = 4'(k % 8);
        else if (k < 18) op = 4'hF;
        else op = 4'($urandom_range(8, 14));
      end
      if ((i % 500) < 40) rdy = ($urandom_range(0, 99) < 5);
      else rdy = ($urandom_range(0, 99) < 70);
      st = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 199) == 0) || (halt_cnt >= 2);
      if (m_halt != 0) halt_cnt++;
      else halt_cnt = 0;
      if (rr) halt_cnt = 0;
      step(rr, op, 1'($urandom_range(0, 1)), rdy, st);
    end

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle control sequencer for the RISC datapath.
- Drives the write enables of the falling-edge D-flip-flop registers: PC, IR and register file.
- Drives the memory read/write strobes and the datapath mux selects.
- Sequences every instruction through FETCH, DECODE, EXEC, optional MEM and WB, with a memory-ready handshake and a wait timeout.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles waiting on MEM_READY in FETCH or MEM before entering ERR (range 1..255)
CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX

Ports:
CLK  input  1  clock; all state updates on falling edge, matching the datapath flops
R  input  1  asynchronous reset, active-high
OPCODE  input  4  IR[15:12], valid from DECODE onward
ZERO  input  1  ALU zero flag, sampled in EXEC
MEM_READY  input  1  memory handshake: access completes on a falling edge where MEM_READY=1
STALL  input  1  freeze request from debug/hazard logic
PC_WE  output  1  PC register write enable
PC_SRC  output  2  00 = PC+1, 01 = branch target, 10 = jump target
IR_WE  output  1  IR write enable
RF_WE  output  1  register file write enable
WB_SEL  output  1  0 = ALU result, 1 = memory data
ALU_SRC  output  1  0 = register, 1 = immediate
MEM_RD  output  1  memory read strobe
MEM_WR  output  1  memory write strobe
STATE  output  3  current state encoding
HALTED  output  1  high in HALT, TRAP or ERR

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6, ERR=7.
- R high (asynchronous, any time, including mid-access):
  - STATE=FETCH, wait counter=0.
  - All outputs 0, except STATE=0.
  - R dominates STALL and MEM_READY.
- Output timing: combinational from state, OPCODE, ZERO and MEM_READY (Mealy); the state register and wait counter are falling-edge flops.
- Opcode classes:
  - 0000-0011: ALU
  - 0100: LOAD
  - 0101: STORE
  - 0110: BEQ
  - 0111: JMP
  - 1111: HALT
  - others: illegal
- FETCH:
  - MEM_RD=1.
  - If MEM_READY=1: IR_WE=1, PC_WE=1, PC_SRC=00, next DECODE.
  - Else stay in FETCH and increment the wait counter.
- DECODE:
  - No enables asserted.
  - Next: EXEC for ALU, LOAD, STORE, BEQ and JMP; HALT for 1111; illegal per optional feature.
- EXEC:
  - ALU_SRC=1 for LOAD and STORE, 0 otherwise.
  - BEQ: PC_WE=ZERO, PC_SRC=01, next FETCH.
  - JMP: PC_WE=1, PC_SRC=10, next FETCH.
  - LOAD and STORE: next MEM.
  - ALU: next WB.
- MEM:
  - LOAD: MEM_RD=1. STORE: MEM_WR=1.
  - On MEM_READY=1: LOAD goes to WB, STORE goes to FETCH.
  - Else stay in MEM and increment the wait counter.
- WB:
  - RF_WE=1.
  - WB_SEL=1 for LOAD, 0 for ALU.
  - Next FETCH.
- HALT, TRAP, ERR:
  - Sticky until R; all enables and strobes 0; HALTED=1.
- Wait counter:
  - Clears on every state change.
  - If the counter equals MEM_WAIT_MAX in FETCH or MEM with MEM_READY=0, next state is ERR.
  - MEM_READY=1 on that same edge wins: the access completes normally.
- STALL=1:
  - State and counter hold.
  - PC_WE, IR_WE, RF_WE and MEM_WR are forced to 0.
  - MEM_RD is held at its state value.
  - A MEM_READY seen during STALL is ignored; the access retries after STALL drops.
- OPCODE is held by the IR from DECODE through WB; the FSM does not latch it.
- At most one of MEM_RD and MEM_WR is high in any cycle.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP (STATE=6, HALTED=1), sticky until R.
- Undefined: an illegal opcode is a NOP. DECODE goes to FETCH with no enables, and TRAP is unreachable.

Test Plan:
1. R pulse of 1 for 2 cycles mid-MEM of a STORE (MEM_WR=1) -> MEM_WR drops immediately; STATE=0 and all enables 0 while R=1; FETCH resumes on the first falling edge after R drops.
2. ALU opcode 0010, MEM_READY tied 1 -> STATE sequence 0,1,2,4,0.
   - IR_WE=PC_WE=1 in FETCH.
   - RF_WE=1 and WB_SEL=0 in WB.
   - 4 cycles per instruction.
3. LOAD 0100 with MEM_READY low for 3 cycles in MEM -> MEM_RD=1 for 4 cycles, then WB with RF_WE=1 and WB_SEL=1. STORE 0101 -> MEM_WR=1 and returns to FETCH with RF_WE never asserted.
4. BEQ 0110: ZERO=1 -> PC_WE=1, PC_SRC=01 in EXEC; ZERO=0 -> PC_WE=0. JMP 0111 -> PC_SRC=10, PC_WE=1.
5. MEM_READY held 0 in FETCH with MEM_WAIT_MAX=15 -> ERR (STATE=7, HALTED=1) on the edge where the counter is 15. Repeat with MEM_READY=1 on that edge -> DECODE, no ERR.
6. Opcode 1000: with ILLEGAL_TRAP_EN -> STATE=6, HALTED=1; without -> back to FETCH. Opcode 1111 -> HALT. STALL=1 in EXEC of JMP for 3 cycles -> PC_WE=0 and STATE=2 held; PC_WE=1 once STALL drops.
